mem_arbiter: RTL and testbench

- Shares one synchronous single-port SRAM between the instruction-fetch port and the data (load/store) port of the MIPS datapath.
- Sits between `datapath` and a unified instruction/data RAM.
- Sequences every access as a two-cycle issue/response transaction.
- Data accesses have priority; a starvation limit guarantees fetch progress.
- Drives a pipeline stall while any request is outstanding.

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-state arbiter sharing one synchronous single-port SRAM between instruction fetch
// and data load/store. Data has priority; a starvation counter eventually forces a pending fetch through.
module mem_arbiter #(
  parameter int MEM_AW     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_rdata_o,
  output logic              if_valid_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_sel_i,
  input  logic [31:0]       d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic [31:0]       d_rdata_o,
  output logic              d_valid_o,
  output logic              stall_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              dbg_state
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  // Handshake: a requester raises req with stable fields and holds them until its
  // valid strobe; it may drop or change the request in the cycle after valid.
  state_t        state, state_nxt;
  logic          owner_d, owner_d_nxt;
  logic          store_q, store_nxt;
  logic [SW-1:0] starve, starve_nxt;
  logic [31:0]   if_hold, d_hold;
  logic          grant_d, grant_if;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[1:0], if_addr_i[31:MEM_AW+2],
                              d_addr_i[1:0], d_addr_i[31:MEM_AW+2]};

  assign dbg_state = state;

  // Grants are suppressed while reset is held so no SRAM access leaks out.
  always_comb begin
    grant_d  = 1'b0;
    grant_if = 1'b0;
    if (state == IDLE && !rst_i) begin
      if (d_req_i && !(if_req_i && starve == SW'(STARVE_MAX))) grant_d = 1'b1;
      else if (if_req_i)                                        grant_if = 1'b1;
    end
  end

  always_comb begin
    mem_en_o    = grant_d | grant_if;
    mem_we_o    = 4'b0000;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    if (grant_d) begin
      mem_addr_o  = d_addr_i[MEM_AW+1:2];
      mem_wdata_o = d_wdata_i;
      mem_we_o    = d_we_i ? d_sel_i : 4'b0000;
    end else if (grant_if) begin
      mem_addr_o = if_addr_i[MEM_AW+1:2];
    end
  end

  always_comb begin
    if_valid_o = (state == RESP) && !owner_d;
    d_valid_o  = (state == RESP) && owner_d;
    if_rdata_o = if_valid_o ? mem_rdata_i : if_hold;
    d_rdata_o  = (d_valid_o && !store_q) ? mem_rdata_i : d_hold;
    stall_o    = (if_req_i & ~if_valid_o) | (d_req_i & ~d_valid_o);
  end

  always_comb begin
    state_nxt   = state;
    owner_d_nxt = owner_d;
    store_nxt   = store_q;
    starve_nxt  = starve;
    case (state)
      IDLE: begin
        if (grant_d || grant_if) begin
          state_nxt   = RESP;
          owner_d_nxt = grant_d;
          store_nxt   = grant_d & d_we_i;
          if (grant_d && if_req_i)
            starve_nxt = (starve == SW'(STARVE_MAX)) ? starve : starve + SW'(1);
          else
            starve_nxt = '0;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      store_q <= 1'b0;
      starve  <= '0;
      if_hold <= 32'h0;
      d_hold  <= 32'h0;
    end else begin
      state   <= state_nxt;
      owner_d <= owner_d_nxt;
      store_q <= store_nxt;
      starve  <= starve_nxt;
      if (if_valid_o)             if_hold <= mem_rdata_i;
      if (d_valid_o && !store_q)  d_hold  <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, then two randomized requesters checked
// against a transaction-level memory model and the arbitration rules.
module tb_mem_arbiter;
  localparam int MEM_AW     = 16;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, d_req, d_we;
  logic [31:0]       if_addr, d_addr, d_wdata;
  logic [3:0]        d_sel;
  logic [31:0]       if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic              if_valid, d_valid, stall, mem_en, dbg_state;
  logic [3:0]        mem_we;
  logic [MEM_AW-1:0] mem_addr;

  mem_arbiter #(.MEM_AW(MEM_AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_valid_o(if_valid),
    .d_req_i(d_req), .d_we_i(d_we), .d_sel_i(d_sel), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_rdata_o(d_rdata), .d_valid_o(d_valid),
    .stall_o(stall), .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: read data appears the cycle after an enabled read.
  logic [31:0] sram [0:65535];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'b0000) mem_rdata <= sram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ref_mem [0:255];
  logic [31:0] if_shown, d_shown;
  logic [31:0] exp_q[$];

  task automatic init_mem();
    for (int i = 0; i < 65536; i++) sram[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    for (int i = 0; i < 256; i++) ref_mem[i] = sram[i];
  endtask

  task automatic do_reset();
    rst = 1'b1; if_req = 0; d_req = 0; d_we = 0; d_sel = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Values presented at the SRAM in the issue cycle, for checking at the response.
  logic              iss_en, iss_if_req, iss_d_req;
  logic [3:0]        iss_we;
  logic [MEM_AW-1:0] iss_addr;
  logic [31:0]       iss_wdata;
  always @(posedge clk) begin
    iss_en     <= mem_en;
    iss_we     <= mem_we;
    iss_addr   <= mem_addr;
    iss_wdata  <= mem_wdata;
    iss_if_req <= if_req;
    iss_d_req  <= d_req;
  end

  // Rule monitor for the randomized phase; d_run counts data wins over a waiting fetch.
  bit rand_on = 0;
  int d_run   = 0;
  always @(negedge clk) begin
    if (rand_on) begin
      check_eq("stall", 32'(stall), 32'((if_req & ~if_valid) | (d_req & ~d_valid)));
      check_eq("one_owner", 32'(if_valid & d_valid), 0);
      check_eq("no_issue_in_resp", 32'(mem_en & (if_valid | d_valid)), 0);
      if (!if_valid) check_eq("if_hold", if_rdata, if_shown);
      if (!d_valid)  check_eq("d_hold", d_rdata, d_shown);
      if (d_valid) begin
        if (iss_if_req) begin
          d_run++;
          check_eq("starve_limit", 32'(d_run <= STARVE_MAX), 1);
        end else d_run = 0;
      end
      if (if_valid) begin
        if (iss_d_req) check_eq("if_forced_at_limit", 32'(d_run), 32'(STARVE_MAX));
        d_run = 0;
      end
    end
  end

  task automatic if_port(input int n);
    int gap, w;
    logic [7:0] word;
    logic [31:0] exp;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin if_req = 0; tick(); end
      word    = 8'($urandom_range(0, 127));
      if_addr = {14'($urandom), 8'h00, word, 2'b00};
      if_req  = 1'b1;
      exp_q.push_back(ref_mem[word]);
      w = 0;
      @(negedge clk);
      while (!if_valid && w < 40) begin w++; @(negedge clk); end
      exp = exp_q.pop_front();
      check_eq("if_wait", 32'(w <= 2 * STARVE_MAX + 2), 1);
      check_eq("if_rdata", if_rdata, exp);
      check_eq("if_issue", 32'({iss_en, iss_we, iss_addr}), 32'({1'b1, 4'b0, 8'h00, word}));
      if_shown = exp;
      tick();
      if_req = 0;
    end
  endtask

  task automatic d_port(input int n);
    int gap, w;
    logic [7:0] word;
    logic [3:0] sel;
    logic [31:0] wd, exp;
    logic we;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin d_req = 0; tick(); end
      we = 1'($urandom_range(0, 1));
      sel = 4'($urandom_range(1, 15));
      wd = $urandom;
      if (we) begin
        word = 8'(128 + $urandom_range(0, 127));
        for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[word][8*b +: 8] = wd[8*b +: 8];
        exp = d_shown;
      end else begin
        word = 8'($urandom_range(0, 255));
        exp = ref_mem[word];
      end
      d_addr = {14'($urandom), 8'h00, word, 2'b00};
      d_we = we; d_sel = sel; d_wdata = wd; d_req = 1'b1;
      w = 0;
      @(negedge clk);
      while (!d_valid && w < 40) begin w++; @(negedge clk); end
      check_eq("d_valid", 32'(d_valid), 1);
      check_eq("d_rdata", d_rdata, exp);
      check_eq("d_issue", 32'({iss_en, iss_we, iss_addr}),
               32'({1'b1, (we ? sel : 4'b0000), 8'h00, word}));
      if (we) check_eq("d_issue_wdata", iss_wdata, wd);
      else    d_shown = exp;
      tick();
      d_req = 0;
    end
  endtask

  logic [6:0] seq;
  int n_resp, if_cyc;
  bit saw_if;

  initial begin
    init_mem();
    rst = 1'b1; if_req = 0; d_req = 0; d_we = 0; d_sel = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0;

    // Reset state
    @(negedge clk);
    check_eq("rst_valid", 32'({if_valid, d_valid}), 0);
    check_eq("rst_mem_ctl", 32'({mem_en, mem_we, mem_addr}), 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_if_rdata", if_rdata, 0);
    check_eq("rst_d_rdata", d_rdata, 0);
    check_eq("rst_stall", 32'(stall), 0);
    check_eq("rst_state", 32'(dbg_state), 0);
    if_req = 1'b1;
    #1;
    check_eq("rst_stall_follows_req", 32'(stall), 1);
    check_eq("rst_no_issue", 32'(mem_en), 0);
    if_req = 1'b0;
    tick();
    rst = 1'b0;

    // Single fetch
    sram[4] = 32'h2402_0005;
    if_req = 1'b1; if_addr = 32'h0000_0010;
    @(negedge clk);
    check_eq("fetch_issue", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 4'b0, 16'd4}));
    check_eq("fetch_stall0", 32'(stall), 1);
    tick(); @(negedge clk);
    check_eq("fetch_valid", 32'(if_valid), 1);
    check_eq("fetch_rdata", if_rdata, 32'h2402_0005);
    check_eq("fetch_stall1", 32'(stall), 0);
    tick(); if_req = 1'b0;
    @(negedge clk);
    check_eq("fetch_rdata_held", if_rdata, 32'h2402_0005);
    check_eq("fetch_valid_drop", 32'(if_valid), 0);

    // Simultaneous load and fetch
    sram[16] = 32'hC0DE_0010;
    sram[2]  = 32'h8FA2_0002;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; if_req = 1'b1; if_addr = 32'h08;
    @(negedge clk);
    check_eq("both_c0_issue", 32'({mem_en, mem_addr}), 32'({1'b1, 16'h10}));
    check_eq("both_c0_stall", 32'(stall), 1);
    tick(); @(negedge clk);
    check_eq("both_c1_valid", 32'({d_valid, if_valid}), 32'b10);
    check_eq("both_c1_rdata", d_rdata, 32'hC0DE_0010);
    check_eq("both_c1_stall", 32'(stall), 1);
    tick(); d_req = 1'b0;
    @(negedge clk);
    check_eq("both_c2_issue", 32'({mem_en, mem_addr}), 32'({1'b1, 16'h2}));
    check_eq("both_c2_stall", 32'(stall), 1);
    tick(); @(negedge clk);
    check_eq("both_c3_valid", 32'(if_valid), 1);
    check_eq("both_c3_rdata", if_rdata, 32'h8FA2_0002);
    check_eq("both_c3_stall", 32'(stall), 0);
    tick(); if_req = 1'b0;

    // Byte store then load of the same word
    sram[16'h41] = 32'h1122_3344;
    d_req = 1'b1; d_we = 1'b1; d_sel = 4'b0010; d_addr = 32'h104; d_wdata = 32'hAABB_CCDD;
    @(negedge clk);
    check_eq("store_issue", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 4'b0010, 16'h41}));
    check_eq("store_wdata", mem_wdata, 32'hAABB_CCDD);
    tick(); @(negedge clk);
    check_eq("store_valid", 32'(d_valid), 1);
    check_eq("store_rdata_unchanged", d_rdata, 32'hC0DE_0010);
    tick(); d_we = 1'b0;
    @(negedge clk);
    check_eq("load_issue", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 4'b0000, 16'h41}));
    tick(); @(negedge clk);
    check_eq("load_valid", 32'(d_valid), 1);
    check_eq("load_merged", d_rdata, 32'h1122_CC44);
    tick(); d_req = 1'b0;

    // Starvation: back-to-back loads against one held fetch
    seq = '0; n_resp = 0; if_cyc = -1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; if_req = 1'b1; if_addr = 32'h20;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      saw_if = if_valid;
      if (d_valid) begin seq = {seq[5:0], 1'b1}; n_resp++; end
      if (if_valid) begin seq = {seq[5:0], 1'b0}; n_resp++; if_cyc = c; end
      tick();
      if (saw_if) if_req = 1'b0;
    end
    d_req = 1'b0;
    check_eq("starve_order", 32'(seq), 32'(7'b1111011));
    check_eq("starve_count", 32'(n_resp), 7);
    check_eq("starve_if_cycle", 32'(if_cyc), 9);

    // Reset asserted mid-response
    tick();
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    tick(); @(negedge clk);
    check_eq("midrst_valid_before", 32'(if_valid), 1);
    #1 rst = 1'b1;
    #1;
    check_eq("midrst_valid_drop", 32'({if_valid, d_valid}), 0);
    check_eq("midrst_state", 32'(dbg_state), 0);
    check_eq("midrst_if_rdata", if_rdata, 0);
    check_eq("midrst_mem_en", 32'(mem_en), 0);
    if_req = 1'b0;
    tick();
    rst = 1'b0;

    // Randomized phase
    init_mem();
    do_reset();
    if_shown = 0; d_shown = 0; d_run = 0;
    rand_on = 1;
    fork
      if_port(60);
      d_port(80);
    join
    rand_on = 0;
    check_eq("exp_q_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
